// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// It produces the PC and IF/ID write enables, ID/EX bubbles on load-use
// hazards, and IF/ID flushes on taken control flow. It freezes the pipe
// while a data-memory access is outstanding and latches a memory timeout.
// All control outputs are combinational from state and inputs. State,
// the wait counter, the stall counter and the timeout flag are registered.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,  // 1..255, bounded by the 8-bit wait counter
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [4:0]       IFID_rs_i,
  input  logic [4:0]       IFID_rt_i,
  input  logic [4:0]       IDEX_rt_i,
  input  logic             IDEX_memread_i,
  input  logic             branch_taken_i,
  input  logic             jump_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             pipe_stall_o,
  output logic             mem_timeout_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    ERROR    = 2'd3
  } state_t;

  state_t           state;
  logic [7:0]       wait_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic             timeout_flag;

  logic luh, cf, mm;

  // Hazard detection terms
  always_comb begin
    luh = IDEX_memread_i && (IDEX_rt_i != 5'd0) &&
          ((IDEX_rt_i == IFID_rs_i) || (IDEX_rt_i == IFID_rt_i));
    cf  = branch_taken_i | jump_i;
    mm  = mem_req_i & ~mem_ack_i;
  end

  // Control outputs; a memory miss beats a load-use stall beats a flush.
  // A load-use stall leaves any same-cycle branch for the next cycle.
  always_comb begin
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_stall_o  = 1'b0;
    case (state)
      RUN: begin
        if (mm) begin
          pipe_stall_o = 1'b1;
        end else if (luh) begin
          idex_bubble_o = 1'b1;
        end else begin
          pc_write_o   = 1'b1;
          ifid_write_o = 1'b1;
          ifid_flush_o = cf;
        end
      end
      MEM_WAIT: begin
        // Hazard inputs are ignored here; the ack cycle is a plain advance
        pipe_stall_o = ~mem_ack_i;
        pc_write_o   = mem_ack_i;
        ifid_write_o = mem_ack_i;
      end
      ERROR: pipe_stall_o = 1'b1;
      default: ;
    endcase
  end

  // Sequencer state, memory wait counter, timeout flag and stall counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      wait_cnt     <= 8'd0;
      stall_cnt    <= '0;
      timeout_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_i) state <= RUN;
        RUN: begin
          if (mm) begin
            state    <= MEM_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        MEM_WAIT: begin
          if (mem_ack_i) begin
            state <= RUN;
          end else if (wait_cnt == 8'(MEM_TIMEOUT)) begin
            state        <= ERROR;
            timeout_flag <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;  // ERROR is left only through reset
      endcase
      if ((state == RUN || state == MEM_WAIT) && !pc_write_o && !(&stall_cnt))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign state_o       = state;
  assign stall_cnt_o   = stall_cnt;
  assign mem_timeout_o = timeout_flag;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized scoreboard bench for pipeline_hazard_ctrl.
// The stimulus process drives inputs just after each rising edge. It
// predicts that cycle's outputs from a behavioural model and queues them.
// The monitor pops and compares on the falling edge.
module tb_pipeline_hazard_ctrl;
  localparam int TO    = 4;
  localparam int CW    = 5;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 0, memread = 0, br = 0, jmp = 0, req = 0, ack = 0;
  logic [4:0] rs = 0, rt = 0, irt = 0;
  logic pc_w, ifid_w, flush, bubble, stall, tmo;
  logic [1:0] st;
  logic [CW-1:0] scnt;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .IFID_rs_i(rs), .IFID_rt_i(rt), .IDEX_rt_i(irt),
    .IDEX_memread_i(memread), .branch_taken_i(br), .jump_i(jmp),
    .mem_req_i(req), .mem_ack_i(ack),
    .pc_write_o(pc_w), .ifid_write_o(ifid_w), .ifid_flush_o(flush),
    .idex_bubble_o(bubble), .pipe_stall_o(stall), .mem_timeout_o(tmo),
    .state_o(st), .stall_cnt_o(scnt)
  );

  typedef struct packed {
    logic          pc_w, ifid_w, flush, bubble, stall, tmo;
    logic [1:0]    st;
    logic [CW-1:0] scnt;
  } exp_t;

  exp_t q[$];
  int n_checks = 0, n_pass = 0;

  // behavioural model: 0 idle, 1 run, 2 waiting on memory, 3 error
  int m_state = 0, m_wait = 0, m_cnt = 0;
  bit m_to = 0;

  task automatic check(input string name, input int act, input int req_v);
    n_checks++;
    if (act == req_v) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req_v);
  endtask

  task automatic model_reset();
    m_state = 0; m_wait = 0; m_cnt = 0; m_to = 0;
  endtask

  // predict this cycle's outputs, then advance the model across the edge
  task automatic predict_and_step();
    exp_t e;
    bit luh, miss;
    e = '0;
    luh  = memread && irt != 0 && (irt == rs || irt == rt);
    miss = req && !ack;
    e.st = 2'(m_state); e.scnt = CW'(m_cnt); e.tmo = m_to;
    if (m_state == 1) begin
      if (miss)      e.stall = 1;
      else if (luh)  e.bubble = 1;
      else begin e.pc_w = 1; e.ifid_w = 1; e.flush = br | jmp; end
    end else if (m_state == 2) begin
      e.pc_w = ack; e.ifid_w = ack; e.stall = !ack;
    end else if (m_state == 3) e.stall = 1;
    q.push_back(e);
    if ((m_state == 1 || m_state == 2) && !e.pc_w && m_cnt < CMAX) m_cnt++;
    case (m_state)
      0: if (start) m_state = 1;
      1: if (miss) begin m_state = 2; m_wait = 1; end
      2: if (ack) m_state = 1;
         else if (m_wait == TO) begin m_state = 3; m_to = 1; end
         else m_wait++;
      default: ;
    endcase
  endtask

  task automatic drive(input logic s, input logic [4:0] a_rs, a_rt, a_irt,
                       input logic mr, b, j, rq, ak);
    @(posedge clk); #1;
    start = s; rs = a_rs; rt = a_rt; irt = a_irt;
    memread = mr; br = b; jmp = j; req = rq; ack = ak;
    predict_and_step();
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // reset asserted mid-cycle must clear everything immediately
  task automatic async_reset();
    @(posedge clk); #3;
    rst = 1;
    #1;
    check("async_rst state", st, 0);
    check("async_rst timeout", tmo, 0);
    check("async_rst stall_cnt", scnt, 0);
    check("async_rst pipe_stall", stall, 0);
    model_reset();
    @(posedge clk); #2;
    rst = 0;
  endtask

  // monitor: every cycle the DUT presents a full output vector
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e, a;
      e = q.pop_front();
      a = {pc_w, ifid_w, flush, bubble, stall, tmo, st, scnt};
      n_checks++;
      if (a === e) n_pass++;
      else $display("FAIL outputs @%0t: got pcw=%b ifw=%b fl=%b bub=%b stl=%b to=%b st=%0d cnt=%0d, required pcw=%b ifw=%b fl=%b bub=%b stl=%b to=%b st=%0d cnt=%0d",
        $time, a.pc_w, a.ifid_w, a.flush, a.bubble, a.stall, a.tmo, a.st, a.scnt,
        e.pc_w, e.ifid_w, e.flush, e.bubble, e.stall, e.tmo, e.st, e.scnt);
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset state", st, 0);
    check("reset pc_write", pc_w, 0);
    check("reset stall_cnt", scnt, 0);
    check("reset timeout", tmo, 0);
    rst = 0;

    // start, then plain advance
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle_in(); idle_in();
    // load-use on rs, then same load with rt=0 (no stall)
    drive(0, 5, 1, 5, 1, 0, 0, 0, 0);
    drive(0, 5, 1, 0, 1, 0, 0, 0, 0);
    // load-use on rt together with a branch, then branch alone
    drive(0, 2, 7, 7, 1, 1, 0, 0, 0);
    drive(0, 2, 7, 7, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    // hit: request acked in the same cycle
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    // miss with ack three cycles after the request
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 3, 3, 3, 1, 1, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 3, 3, 3, 1, 1, 0, 1, 1);
    idle_in();
    // miss that never completes: timeout into error, then async reset
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (TO + 2) drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    async_reset();
    // stall counter saturation: 40 load-use cycles
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (40) drive(0, 4, 0, 4, 1, 0, 0, 0, 0);
    idle_in();
    async_reset();

    // randomized traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) async_reset();
      else drive($urandom_range(0, 3) == 0,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 6) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0);
    end

    repeat (2) @(posedge clk);
    check("scoreboard drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
